// File: rtl/fir_xifu_wb_ctrl.sv
// In-order writeback tracker for the FIR XIFU: entries wait for commit and
// memory result, then retire in issue order onto the XIF result interface.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// FREE        | slot unused
// WAIT_COMMIT | issued, waiting for XIF commit (mem_done may already be set)
// WAIT_MEM    | committed, waiting for the memory result
// READY       | result may be returned once it reaches the head
// KILLED      | commit was a kill; freed silently when at the head
module fir_xifu_wb_ctrl #(
    parameter int DEPTH = 4,
    parameter int ID_W  = 4,
    parameter int RD_W  = 5
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            issue_valid_i,
    output logic            issue_ready_o,
    input  logic [ID_W-1:0] issue_id_i,
    input  logic            issue_mem_i,
    input  logic            issue_rfw_i,
    input  logic [RD_W-1:0] issue_rd_i,
    input  logic            commit_valid_i,
    input  logic [ID_W-1:0] commit_id_i,
    input  logic            commit_kill_i,
    input  logic            mem_result_valid_i,
    input  logic [ID_W-1:0] mem_result_id_i,
    output logic            result_valid_o,
    input  logic            result_ready_i,
    output logic [ID_W-1:0] result_id_o,
    output logic            rf_write_o,
    output logic [RD_W-1:0] rf_rd_o,
    output logic            unexpected_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef enum logic [2:0] {
        FREE,
        WAIT_COMMIT,
        WAIT_MEM,
        READY,
        KILLED
    } ent_state_e;

    ent_state_e       state_q [DEPTH];
    ent_state_e       state_d [DEPTH];
    logic [ID_W-1:0]  id_q    [DEPTH];
    logic [ID_W-1:0]  id_d    [DEPTH];
    logic [RD_W-1:0]  rd_q    [DEPTH];
    logic [RD_W-1:0]  rd_d    [DEPTH];
    logic [DEPTH-1:0] mem_q, mem_d;
    logic [DEPTH-1:0] rfw_q, rfw_d;
    logic [DEPTH-1:0] mem_done_q, mem_done_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             unexpected_q, unexpected_d;
    logic             issue_fire;
    logic             head_free;
    logic             commit_hit;
    logic             mem_hit;

    // Outputs are forced low during reset so nothing leaks from stale state.
    assign issue_ready_o  = !rst_i && (count_q < CNT_W'(DEPTH));
    assign issue_fire     = issue_valid_i && issue_ready_o;
    assign result_valid_o = !rst_i && (state_q[rd_ptr_q] == READY);
    assign result_id_o    = rst_i ? '0 : id_q[rd_ptr_q];
    assign rf_rd_o        = rst_i ? '0 : rd_q[rd_ptr_q];
    assign rf_write_o     = result_valid_o && result_ready_i && rfw_q[rd_ptr_q];
    assign unexpected_o   = unexpected_q && !rst_i;
    assign head_free      = !rst_i && ((state_q[rd_ptr_q] == KILLED) ||
                                       (result_valid_o && result_ready_i));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= '{default: FREE};
            id_q         <= '{default: '0};
            rd_q         <= '{default: '0};
            mem_q        <= '0;
            rfw_q        <= '0;
            mem_done_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            unexpected_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            id_q         <= id_d;
            rd_q         <= rd_d;
            mem_q        <= mem_d;
            rfw_q        <= rfw_d;
            mem_done_q   <= mem_done_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            unexpected_q <= unexpected_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        rd_d       = rd_q;
        mem_d      = mem_q;
        rfw_d      = rfw_q;
        mem_done_d = mem_done_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        commit_hit = 1'b0;
        mem_hit    = 1'b0;

        // Allocate first so a same-cycle commit or memory result sees the new entry.
        if (issue_fire) begin
            state_d[wr_ptr_q]    = WAIT_COMMIT;
            id_d[wr_ptr_q]       = issue_id_i;
            rd_d[wr_ptr_q]       = issue_rd_i;
            mem_d[wr_ptr_q]      = issue_mem_i;
            rfw_d[wr_ptr_q]      = issue_rfw_i;
            mem_done_d[wr_ptr_q] = 1'b0;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end

        for (int i = 0; i < DEPTH; i++) begin
            if (mem_result_valid_i && (id_d[i] == mem_result_id_i)) begin
                if (state_d[i] == WAIT_COMMIT) begin
                    mem_done_d[i] = 1'b1;
                    mem_hit       = 1'b1;
                end else if (state_d[i] == WAIT_MEM) begin
                    state_d[i] = READY;
                    mem_hit    = 1'b1;
                end
            end
            if (commit_valid_i && (state_d[i] == WAIT_COMMIT) && (id_d[i] == commit_id_i)) begin
                commit_hit = 1'b1;
                if (commit_kill_i) begin
                    state_d[i] = KILLED;
                end else if (!mem_d[i] || mem_done_d[i]) begin
                    state_d[i] = READY;
                end else begin
                    state_d[i] = WAIT_MEM;
                end
            end
        end

        if (head_free) begin
            state_d[rd_ptr_q] = FREE;
            rd_ptr_d          = rd_ptr_q + PTR_W'(1);
        end

        count_d      = count_q + CNT_W'(issue_fire) - CNT_W'(head_free);
        unexpected_d = (commit_valid_i && !commit_hit) ||
                       (mem_result_valid_i && !mem_hit);
    end

endmodule

// File: tb/tb_fir_xifu_wb_ctrl.sv
// Bench for fir_xifu_wb_ctrl: directed scenarios plus random traffic, all
// checked against an issue-ordered queue model of the tracked instructions.
module tb_fir_xifu_wb_ctrl;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic       rst;
        logic       iv;
        logic [3:0] iid;
        logic       im;
        logic       irfw;
        logic [4:0] ird;
        logic       cv;
        logic [3:0] cid;
        logic       ck;
        logic       mv;
        logic [3:0] mid;
        logic       rr;
    } stim_t;

    typedef struct {
        logic [3:0] id;
        bit         mem;
        bit         rfw;
        logic [4:0] rd;
        bit         committed;
        bit         killed;
        bit         mem_done;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       issue_valid, issue_ready;
    logic [3:0] issue_id;
    logic       issue_mem, issue_rfw;
    logic [4:0] issue_rd;
    logic       commit_valid;
    logic [3:0] commit_id;
    logic       commit_kill;
    logic       mem_result_valid;
    logic [3:0] mem_result_id;
    logic       result_valid, result_ready;
    logic [3:0] result_id;
    logic       rf_write;
    logic [4:0] rf_rd;
    logic       unexpected;

    ent_t mq[$];
    bit   m_unexp;
    int   n_vec = 0;
    int   n_err = 0;

    logic       got_ready, got_valid, got_rfw, got_unexp;
    logic [3:0] got_id;
    logic [4:0] got_rd;

    always #5 clk = ~clk;

    fir_xifu_wb_ctrl #(.DEPTH(DEPTH), .ID_W(4), .RD_W(5)) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .issue_valid_i      (issue_valid),
        .issue_ready_o      (issue_ready),
        .issue_id_i         (issue_id),
        .issue_mem_i        (issue_mem),
        .issue_rfw_i        (issue_rfw),
        .issue_rd_i         (issue_rd),
        .commit_valid_i     (commit_valid),
        .commit_id_i        (commit_id),
        .commit_kill_i      (commit_kill),
        .mem_result_valid_i (mem_result_valid),
        .mem_result_id_i    (mem_result_id),
        .result_valid_o     (result_valid),
        .result_ready_i     (result_ready),
        .result_id_o        (result_id),
        .rf_write_o         (rf_write),
        .rf_rd_o            (rf_rd),
        .unexpected_o       (unexpected)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit head_ready();
        if (mq.size() == 0) return 1'b0;
        return mq[0].committed && !mq[0].killed && (!mq[0].mem || mq[0].mem_done);
    endfunction

    function automatic bit id_busy(input logic [3:0] id);
        foreach (mq[i]) if (mq[i].id == id) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_update(input stim_t s);
        bit   freed, chit, mhit;
        ent_t e;
        if (s.rst) begin
            mq.delete();
            m_unexp = 1'b0;
            return;
        end
        freed = (mq.size() > 0) && (mq[0].killed || (head_ready() && s.rr));
        if (s.iv && mq.size() < DEPTH) begin
            e.id = s.iid; e.mem = s.im; e.rfw = s.irfw; e.rd = s.ird;
            e.committed = 1'b0; e.killed = 1'b0; e.mem_done = 1'b0;
            mq.push_back(e);
        end
        mhit = 1'b0;
        if (s.mv) begin
            foreach (mq[i]) begin
                if (!mhit && mq[i].id == s.mid && !mq[i].killed &&
                    (!mq[i].committed || (mq[i].mem && !mq[i].mem_done))) begin
                    mq[i].mem_done = 1'b1;
                    mhit = 1'b1;
                end
            end
        end
        chit = 1'b0;
        if (s.cv) begin
            foreach (mq[i]) begin
                if (!chit && !mq[i].committed && mq[i].id == s.cid) begin
                    mq[i].committed = 1'b1;
                    mq[i].killed    = s.ck;
                    chit = 1'b1;
                end
            end
        end
        m_unexp = (s.cv && !chit) || (s.mv && !mhit);
        if (freed) void'(mq.pop_front());
    endtask

    task automatic cycle(input stim_t s);
        bit e_valid;
        @(negedge clk);
        rst = s.rst; issue_valid = s.iv; issue_id = s.iid; issue_mem = s.im;
        issue_rfw = s.irfw; issue_rd = s.ird; commit_valid = s.cv; commit_id = s.cid;
        commit_kill = s.ck; mem_result_valid = s.mv; mem_result_id = s.mid;
        result_ready = s.rr;
        #1;
        got_ready = issue_ready; got_valid = result_valid; got_rfw = rf_write;
        got_unexp = unexpected;  got_id = result_id;       got_rd = rf_rd;
        e_valid = !s.rst && head_ready();
        check_val("issue_ready", 32'(got_ready), 32'(!s.rst && mq.size() < DEPTH));
        check_val("result_valid", 32'(got_valid), 32'(e_valid));
        check_val("rf_write", 32'(got_rfw), 32'(e_valid && s.rr && mq[0].rfw));
        check_val("unexpected", 32'(got_unexp), 32'(!s.rst && m_unexp));
        if (e_valid) begin
            check_val("result_id", 32'(got_id), 32'(mq[0].id));
            check_val("rf_rd", 32'(got_rd), 32'(mq[0].rd));
        end else if (s.rst) begin
            check_val("rst_result_id", 32'(got_id), 32'd0);
            check_val("rst_rf_rd", 32'(got_rd), 32'd0);
        end
        @(posedge clk);
        model_update(s);
    endtask

    task automatic gen_random(output stim_t s);
        logic [3:0] cand[$];
        bit         accept;
        s = '0;
        s.rst  = ($urandom_range(0, 79) == 0);
        s.iv   = 1'($urandom_range(0, 1));
        s.iid  = 4'($urandom);
        for (int k = 0; k < 64 && id_busy(s.iid); k++) s.iid = 4'($urandom);
        s.im   = 1'($urandom_range(0, 1));
        s.irfw = 1'($urandom_range(0, 1));
        s.ird  = 5'($urandom);
        accept = s.iv && !s.rst && mq.size() < DEPTH;
        foreach (mq[i]) if (!mq[i].committed) cand.push_back(mq[i].id);
        if (accept) cand.push_back(s.iid);
        s.cv = 1'($urandom_range(0, 1));
        s.ck = ($urandom_range(0, 4) == 0);
        if (cand.size() > 0 && $urandom_range(0, 7) != 0)
            s.cid = cand[$urandom_range(0, cand.size() - 1)];
        else
            s.cid = 4'($urandom);
        cand.delete();
        foreach (mq[i]) if (mq[i].mem && !mq[i].mem_done && !mq[i].killed) cand.push_back(mq[i].id);
        if (accept && s.im) cand.push_back(s.iid);
        s.mv = ($urandom_range(0, 2) == 0);
        if (cand.size() > 0 && $urandom_range(0, 7) != 0)
            s.mid = cand[$urandom_range(0, cand.size() - 1)];
        else
            s.mid = 4'($urandom);
        s.rr = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        stim_t s;
        rst = 1'b1; issue_valid = 0; issue_id = 0; issue_mem = 0; issue_rfw = 0;
        issue_rd = 0; commit_valid = 0; commit_id = 0; commit_kill = 0;
        mem_result_valid = 0; mem_result_id = 0; result_ready = 0;

        s = '0; s.rst = 1; cycle(s); cycle(s);
        check_val("reset_ready_low", 32'(got_ready), 32'd0);
        s = '0; cycle(s);
        check_val("post_reset_ready", 32'(got_ready), 32'd1);

        // single xfirdotp
        s = '0; s.iv = 1; s.iid = 3; s.irfw = 1; s.ird = 7; cycle(s);
        s = '0; s.cv = 1; s.cid = 3; s.rr = 1; cycle(s);
        check_val("dotp_not_early", 32'(got_valid), 32'd0);
        s = '0; s.rr = 1; cycle(s);
        check_val("dotp_valid", 32'(got_valid), 32'd1);
        check_val("dotp_id", 32'(got_id), 32'd3);
        check_val("dotp_rfw", 32'(got_rfw), 32'd1);
        s = '0; cycle(s);
        check_val("dotp_done", 32'(got_valid), 32'd0);

        // xfirlw, memory result before commit
        s = '0; s.iv = 1; s.iid = 5; s.im = 1; s.irfw = 1; s.ird = 2; cycle(s);
        s = '0; s.mv = 1; s.mid = 5; cycle(s);
        s = '0; s.cv = 1; s.cid = 5; cycle(s);
        check_val("lw_not_early", 32'(got_valid), 32'd0);
        s = '0; s.rr = 1; cycle(s);
        check_val("lw_id", 32'(got_id), 32'd5);
        check_val("lw_rfw", 32'(got_rfw), 32'd1);

        // commits out of order, results in order
        s = '0; s.iv = 1; s.iid = 1; cycle(s);
        s.iid = 2; cycle(s);
        s = '0; s.cv = 1; s.cid = 2; s.rr = 1; cycle(s);
        s.cid = 1; cycle(s);
        s = '0; s.rr = 1; cycle(s);
        check_val("rev_first", 32'(got_id), 32'd1);
        cycle(s);
        check_val("rev_second", 32'(got_id), 32'd2);
        check_val("rev_second_valid", 32'(got_valid), 32'd1);

        // kill at the head
        s = '0; s.iv = 1; s.iid = 7; cycle(s);
        s.iid = 8; cycle(s);
        s = '0; s.cv = 1; s.cid = 7; s.ck = 1; s.rr = 1; cycle(s);
        check_val("kill_no_result", 32'(got_valid), 32'd0);
        s.cid = 8; s.ck = 0; cycle(s);
        check_val("kill_no_result2", 32'(got_valid), 32'd0);
        s = '0; s.rr = 1; cycle(s);
        check_val("kill_next_id", 32'(got_id), 32'd8);
        cycle(s);
        check_val("kill_empty", 32'(got_valid), 32'd0);

        // full and wrap
        for (int k = 1; k <= 4; k++) begin
            s = '0; s.iv = 1; s.iid = 4'(k); cycle(s);
        end
        s = '0; cycle(s);
        check_val("full_ready_low", 32'(got_ready), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            s = '0; s.cv = 1; s.cid = 4'(k); cycle(s);
        end
        s = '0; s.rr = 1; cycle(s);
        check_val("full_still_low", 32'(got_ready), 32'd0);
        s = '0; s.iv = 1; s.iid = 5; cycle(s);
        check_val("full_ready_back", 32'(got_ready), 32'd1);
        s = '0; s.cv = 1; s.cid = 5; s.rr = 1; cycle(s);
        s = '0; s.rr = 1;
        for (int k = 0; k < 6; k++) cycle(s);

        // unexpected commit on an empty buffer
        s = '0; s.cv = 1; s.cid = 9; cycle(s);
        s = '0; cycle(s);
        check_val("unexp_pulse", 32'(got_unexp), 32'd1);
        cycle(s);
        check_val("unexp_clear", 32'(got_unexp), 32'd0);

        // reset with live entries
        for (int k = 10; k <= 12; k++) begin
            s = '0; s.iv = 1; s.iid = 4'(k); s.cv = 1; s.cid = 4'(k); cycle(s);
        end
        s = '0; s.rst = 1; s.rr = 1; cycle(s);
        check_val("rst_valid_low", 32'(got_valid), 32'd0);
        s = '0; s.rr = 1; cycle(s);
        check_val("rst_release_ready", 32'(got_ready), 32'd1);
        check_val("rst_no_result", 32'(got_valid), 32'd0);

        for (int n = 0; n < 4000; n++) begin
            gen_random(s);
            cycle(s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
